decodificador_caracter: RTL and testbench
=========================================

// Module: decodificador_caracter
// PURPOSE
//  Inverse of the character-code encoder: takes a 3-bit character code (L,N,C,D,S,V = 1..6) and
//  streams the 12-bit character-ROM address {MSB,LSB} of that glyph, WORDS consecutive addresses per code.
//  Sits between the menu/control logic (code producer) and the character ROM / display path (address consumer).
//  Valid/ready handshake on both sides; one code in flight at a time.
// PARAMETERS
//  WORDS   2   addresses emitted per code (base, base+1, ...); legal 1..16
// PORTS
//  clk         in   1   single clock; everything is synchronous to its rising edge
//  reset       in   1   synchronous, active-high reset
//  code_valid  in   1   code present on code
//  code        in   3   character code: 001 L, 010 N, 011 C, 100 D, 101 S, 110 V
//  code_ready  out  1   block can accept a code (high only in IDLE)
//  adr_valid   out  1   MSB/LSB hold a valid address
//  adr_ready   in   1   consumer accepts current address
//  MSB         out  5   address bits [11:7]
//  LSB         out  7   address bits [6:0]
//  adr_last    out  1   current address is the last (WORDS-th) of the glyph
//  err         out  1   one-cycle pulse: illegal code (000 or 111) was offered
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; code_ready=1 after reset deasserts; adr_valid=0, MSB=0, LSB=0,
//   adr_last=0, err=0, word counter=0. Reset mid-STREAM aborts the glyph; no further addresses emitted.
//  Base table: L 0x726, N 0x728, C 0x72A, D 0x826, S 0x828, V 0x82A (adr = {MSB,LSB}).
//  FSM IDLE: code_ready=1, adr_valid=0. On code_valid & legal code: register base into adr, cnt=0,
//   go STREAM (adr_valid=1 next cycle; latency code accept -> first address = 1 cycle).
//   On code_valid & illegal code: err=1 next cycle for exactly one cycle, stay IDLE, code consumed.
//  FSM STREAM: code_ready=0, adr_valid=1, adr_last=(cnt==WORDS-1). MSB/LSB held stable while adr_ready=0.
//   On adr_ready & !adr_last: adr<=adr+1 (12-bit, wraps 0xFFF->0x000), cnt<=cnt+1.
//   On adr_ready & adr_last: adr_valid=0, go IDLE next cycle (code_ready=1 then); no back-to-back
//   acceptance in the same cycle as the last transfer.
//  code_valid while in STREAM is ignored (code_ready=0); producer must hold it until accepted.
//  adr_ready while adr_valid=0 has no effect. MSB/LSB keep last value after the glyph ends.
//  Throughput: WORDS+1 cycles per code minimum with adr_ready tied high.
//  Round-trip property: encoder({MSB,LSB}) of the first address of every glyph == accepted code.
// STRUCTURE
//  Shared package: code constants (COD_L..COD_V, COD_NONE=000), base-address constants (ADR_L..ADR_V),
//   FSM state encoding (ST_IDLE, ST_STREAM); the encoder uses the same constants.
//  One sub-module: tabla_base_caracter (combinational code[2:0] -> base[11:0], legal flag).
//  Top holds FSM, 12-bit address register, $clog2(WORDS)-bit counter (min 1 bit), err flop.
// TESTING
//  1 Reset, then code=001 valid 1 cycle, adr_ready=1 -> 0x726 (MSB=01110,LSB=0100110), then 0x727 with
//    adr_last=1, then code_ready=1; err never set.
//  2 All six codes back-to-back, adr_ready=1 -> bases 0x726,0x728,0x72A,0x826,0x828,0x82A; first address
//    fed to the encoder returns the original code.
//  3 Backpressure: code=110, adr_ready low 5 cycles -> 0x82A held stable, adr_valid=1, adr_last=0;
//    release -> 0x82B with adr_last=1.
//  4 Illegal codes 000 and 111 -> err high exactly one cycle each, adr_valid stays 0, code_ready stays 1.
//  5 Reset asserted in STREAM after first transfer -> next cycle adr_valid=0, MSB/LSB=0, code_ready=1.
//  6 code_valid with code=100 during STREAM of 010 -> ignored; after 010 glyph completes, 100 accepted
//    (producer still holding) -> 0x826 emitted.

Source files
------------

// File: rtl/decodificador_caracter_pkg.sv
// Shared constants for the character-code encoder/decoder pair: codes, glyph base
// addresses in the character ROM and the decoder FSM state encoding.
package decodificador_caracter_pkg;

  localparam logic [2:0] COD_NONE = 3'b000;
  localparam logic [2:0] COD_L    = 3'b001;
  localparam logic [2:0] COD_N    = 3'b010;
  localparam logic [2:0] COD_C    = 3'b011;
  localparam logic [2:0] COD_D    = 3'b100;
  localparam logic [2:0] COD_S    = 3'b101;
  localparam logic [2:0] COD_V    = 3'b110;

  localparam logic [11:0] ADR_L = 12'h726;
  localparam logic [11:0] ADR_N = 12'h728;
  localparam logic [11:0] ADR_C = 12'h72A;
  localparam logic [11:0] ADR_D = 12'h826;
  localparam logic [11:0] ADR_S = 12'h828;
  localparam logic [11:0] ADR_V = 12'h82A;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Encoder direction: maps a glyph base address back to its character code.
  function automatic logic [2:0] codificar_adr(input logic [11:0] adr);
    logic [2:0] cod;
    cod = COD_NONE;
    case (adr)
      ADR_L:   cod = COD_L;
      ADR_N:   cod = COD_N;
      ADR_C:   cod = COD_C;
      ADR_D:   cod = COD_D;
      ADR_S:   cod = COD_S;
      ADR_V:   cod = COD_V;
      default: cod = COD_NONE;
    endcase
    return cod;
  endfunction

endpackage

// File: rtl/tabla_base_caracter.sv
// Combinational lookup from a 3-bit character code to the glyph base address in the
// character ROM; codes 000 and 111 are flagged as not legal.
module tabla_base_caracter
  import decodificador_caracter_pkg::*;
(
  input  logic [2:0]  code,
  output logic [11:0] base,
  output logic        legal
);

  always_comb begin
    base  = 12'h000;
    legal = 1'b1;
    case (code)
      COD_L:   base = ADR_L;
      COD_N:   base = ADR_N;
      COD_C:   base = ADR_C;
      COD_D:   base = ADR_D;
      COD_S:   base = ADR_S;
      COD_V:   base = ADR_V;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/decodificador_caracter.sv
// Character-code decoder: accepts one code at a time and streams WORDS consecutive
// character-ROM addresses {MSB,LSB} for that glyph over a valid/ready interface.
module decodificador_caracter
  import decodificador_caracter_pkg::*;
#(
  parameter int unsigned WORDS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  output logic       adr_valid,
  input  logic       adr_ready,
  output logic [4:0] MSB,
  output logic [6:0] LSB,
  output logic       adr_last,
  output logic       err
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  state_t          state, state_nxt;
  logic [11:0]     adr, adr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            err_q, err_nxt;
  logic [11:0]     base;
  logic            legal;

  tabla_base_caracter u_tabla (
    .code  (code),
    .base  (base),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      adr   <= 12'h000;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      adr   <= adr_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Illegal codes are consumed in IDLE and only raise a one-cycle err pulse.
  always_comb begin
    state_nxt  = state;
    adr_nxt    = adr;
    cnt_nxt    = cnt;
    err_nxt    = 1'b0;
    code_ready = 1'b0;
    adr_valid  = 1'b0;
    adr_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        code_ready = 1'b1;
        if (code_valid) begin
          if (legal) begin
            adr_nxt   = base;
            cnt_nxt   = '0;
            state_nxt = ST_STREAM;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        adr_valid = 1'b1;
        adr_last  = (cnt == LAST_CNT);
        if (adr_ready) begin
          if (adr_last) begin
            state_nxt = ST_IDLE;
          end else begin
            adr_nxt = adr + 12'd1;
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign MSB = adr[11:7];
  assign LSB = adr[6:0];
  assign err = err_q;

endmodule

// File: tb/tb_decodificador_caracter.sv
// Directed bench for decodificador_caracter (WORDS=2): a vector table for the basic
// streaming and illegal-code cases plus hand sequences for backpressure, reset and holding.
module tb_decodificador_caracter;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [2:0] code;
  logic       code_ready;
  logic       adr_valid;
  logic       adr_ready;
  logic [4:0] MSB;
  logic [6:0] LSB;
  logic       adr_last;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  decodificador_caracter #(.WORDS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .adr_valid  (adr_valid),
    .adr_ready  (adr_ready),
    .MSB        (MSB),
    .LSB        (LSB),
    .adr_last   (adr_last),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        cv;
    logic [2:0]  cd;
    logic        ar;
    logic        e_cr;
    logic        e_av;
    logic [11:0] e_adr;
    logic        e_last;
    logic        e_err;
    logic        rt;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] bases [6];

  function automatic vec_t mk(string name, logic rst, logic cv, logic [2:0] cd, logic ar,
                              logic e_cr, logic e_av, logic [11:0] e_adr, logic e_last,
                              logic e_err, logic rt);
    vec_t v;
    v.name = name; v.rst = rst; v.cv = cv; v.cd = cd; v.ar = ar;
    v.e_cr = e_cr; v.e_av = e_av; v.e_adr = e_adr; v.e_last = e_last;
    v.e_err = e_err; v.rt = rt;
    return v;
  endfunction

  // Independent reverse lookup of a base address to its code (0 when not a base).
  function automatic logic [2:0] bench_encode(logic [11:0] a);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 6; i++) if (bases[i] == a) c = 3'(i + 1);
    return c;
  endfunction

  task automatic cmp(string name, logic [11:0] got, logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(logic rst, logic cv, logic [2:0] cd, logic ar);
    reset      = rst;
    code_valid = cv;
    code       = cd;
    adr_ready  = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic e_cr, logic e_av, logic [11:0] e_adr,
                             logic e_last, logic e_err);
    cmp({name, ".code_ready"}, 12'(code_ready), 12'(e_cr));
    cmp({name, ".adr_valid"},  12'(adr_valid),  12'(e_av));
    cmp({name, ".adr"},        {MSB, LSB},      e_adr);
    cmp({name, ".adr_last"},   12'(adr_last),   12'(e_last));
    cmp({name, ".err"},        12'(err),        12'(e_err));
  endtask

  initial begin
    bases[0] = 12'h726; bases[1] = 12'h728; bases[2] = 12'h72A;
    bases[3] = 12'h826; bases[4] = 12'h828; bases[5] = 12'h82A;

    reset = 1'b1; code_valid = 1'b0; code = 3'd0; adr_ready = 1'b0;

    vecs.push_back(mk("rst",    1, 0, 3'd0, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk("t1_acc", 0, 1, 3'd1, 1, 0, 1, 12'h726, 0, 0, 1));
    vecs.push_back(mk("t1_w1",  0, 0, 3'd0, 1, 0, 1, 12'h727, 1, 0, 0));
    vecs.push_back(mk("t1_end", 0, 0, 3'd0, 1, 1, 0, 12'h727, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk($sformatf("t2_acc%0d", i + 1), 0, 1, 3'(i + 1), 1,
                        0, 1, bases[i], 0, 0, 1));
      vecs.push_back(mk($sformatf("t2_w1_%0d", i + 1), 0, 0, 3'd0, 1,
                        0, 1, bases[i] + 12'd1, 1, 0, 0));
      vecs.push_back(mk($sformatf("t2_end%0d", i + 1), 0, 0, 3'd0, 1,
                        1, 0, bases[i] + 12'd1, 0, 0, 0));
    end
    vecs.push_back(mk("t4_ill0",     0, 1, 3'd0, 1, 1, 0, 12'h82B, 0, 1, 0));
    vecs.push_back(mk("t4_ill0_clr", 0, 0, 3'd0, 1, 1, 0, 12'h82B, 0, 0, 0));
    vecs.push_back(mk("t4_ill7",     0, 1, 3'd7, 1, 1, 0, 12'h82B, 0, 1, 0));
    vecs.push_back(mk("t4_ill7_clr", 0, 0, 3'd0, 1, 1, 0, 12'h82B, 0, 0, 0));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].cv, vecs[k].cd, vecs[k].ar);
      checkOutput(vecs[k].name, vecs[k].e_cr, vecs[k].e_av, vecs[k].e_adr,
                  vecs[k].e_last, vecs[k].e_err);
      if (vecs[k].rt)
        cmp({vecs[k].name, ".roundtrip"}, 12'(bench_encode({MSB, LSB})), 12'(vecs[k].cd));
    end

    // Backpressure: first address of V must hold while the consumer stalls.
    applyStimulus(0, 1, 3'd6, 0);
    checkOutput("t3_acc", 0, 1, 12'h82A, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 3'd0, 0);
      checkOutput($sformatf("t3_hold%0d", i), 0, 1, 12'h82A, 0, 0);
    end
    applyStimulus(0, 0, 3'd0, 1);
    checkOutput("t3_w1", 0, 1, 12'h82B, 1, 0);
    applyStimulus(0, 0, 3'd0, 1);
    checkOutput("t3_end", 1, 0, 12'h82B, 0, 0);

    // Reset in the middle of a glyph aborts it.
    applyStimulus(0, 1, 3'd3, 1);
    checkOutput("t5_acc", 0, 1, 12'h72A, 0, 0);
    applyStimulus(0, 0, 3'd0, 1);
    checkOutput("t5_w1", 0, 1, 12'h72B, 1, 0);
    applyStimulus(1, 0, 3'd0, 0);
    checkOutput("t5_rst", 1, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 3'd0, 1);
    checkOutput("t5_after", 1, 0, 12'h000, 0, 0);

    // A code offered during STREAM is held by the producer and taken once IDLE.
    applyStimulus(0, 1, 3'd2, 1);
    checkOutput("t6_acc", 0, 1, 12'h728, 0, 0);
    applyStimulus(0, 1, 3'd4, 1);
    checkOutput("t6_w1", 0, 1, 12'h729, 1, 0);
    applyStimulus(0, 1, 3'd4, 1);
    checkOutput("t6_end", 1, 0, 12'h729, 0, 0);
    applyStimulus(0, 1, 3'd4, 1);
    checkOutput("t6_acc2", 0, 1, 12'h826, 0, 0);
    applyStimulus(0, 0, 3'd0, 1);
    checkOutput("t6_w1_2", 0, 1, 12'h827, 1, 0);
    applyStimulus(0, 0, 3'd0, 1);
    checkOutput("t6_end2", 1, 0, 12'h827, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
